// File: rtl/pos_read_scheduler.sv
// ---------------------------------------------------------------------------
// pos_read_scheduler
// Runs the position-read sequence for one home cell. It reads the count word,
// then pairs every home reference particle with every neighbour particle
// slot in two halves (phase 0 = cells 0..6, phase 1 = cells 7..13). It stalls
// on filter back-pressure, waits for the pipeline to drain, and then pulses
// done.
//
// Ports
//   clk                  in   clock
//   rst                  in   asynchronous reset, active low
//   start                in   begin a cell (rising edge in IDLE only)
//   home_count           in   home-cell particle count, sampled in LATCH
//   nb_max_count         in   largest neighbour-cell count, sampled in LATCH
//   back_pressure        in   a filter input buffer is almost full
//   phase                out  neighbour half select
//   reading_particle_num out  count-word read strobe
//   pause_reading        out  the current sweep beat is not valid
//   ref_id               out  home reference particle (1-based)
//   particle_id          out  neighbour slot / cache read address (0 = count)
//   busy                 out  high from an accepted start through done
//   done                 out  one-cycle end-of-cell pulse
// ---------------------------------------------------------------------------
module pos_read_scheduler #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int DRAIN_CYCLES      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH-1:0] home_count,
  input  logic [PARTICLE_ID_WIDTH-1:0] nb_max_count,
  input  logic                         back_pressure,
  output logic                         phase,
  output logic                         reading_particle_num,
  output logic                         pause_reading,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = PARTICLE_ID_WIDTH;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [W-1:0]  ONE      = W'(1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_NUM, S_LATCH, S_SWEEP, S_DRAIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic          rpn_q, rpn_d;
  logic          pause_q, pause_d;
  logic [W-1:0]  ref_q, ref_d;
  logic [W-1:0]  pid_q, pid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  lim_q, lim_d;
  logic [W-1:0]  hc_q, hc_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          start_prev_q, start_prev_d;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rpn_d        = 1'b0;
    pause_d      = 1'b0;
    ref_d        = ref_q;
    pid_d        = pid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lim_d        = lim_q;
    hc_d         = hc_q;
    drain_d      = drain_q;
    start_prev_d = start;

    case (state_q)
      S_IDLE: begin
        // Only a fresh edge starts a cell, so a held start cannot re-arm.
        if (start && !start_prev_q) begin
          state_d = S_RD_NUM;
          busy_d  = 1'b1;
          rpn_d   = 1'b1;
          phase_d = 1'b0;
          pid_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_NUM: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // The sweep must cover the home cell too, so it runs to max(home, nb).
        lim_d = (nb_max_count > home_count) ? nb_max_count : home_count;
        hc_d  = home_count;
        if (home_count == '0) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          state_d = S_SWEEP;
          pid_d   = ONE;
          ref_d   = ONE;
          phase_d = 1'b0;
        end
      end
      S_SWEEP: begin
        if (back_pressure) begin
          // Hold the beat; it is presented again as soon as pressure drops.
          pause_d = 1'b1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (pid_q == lim_q) begin
            pid_d = ONE;
            // ref_id ends at hc+1 (it may wrap), which flags reading_done downstream.
            ref_d = ref_q + ONE;
            if (ref_q == hc_q) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end else begin
              state_d = S_SWEEP;
            end
          end else begin
            pid_d = pid_q + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ref_d   = ONE;
        pid_d   = '0;
        phase_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ref_d   = ONE;
        pid_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  // State and output registers; the reset aborts any cell in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      rpn_q        <= 1'b0;
      pause_q      <= 1'b0;
      ref_q        <= ONE;
      pid_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lim_q        <= '0;
      hc_q         <= '0;
      drain_q      <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rpn_q        <= rpn_d;
      pause_q      <= pause_d;
      ref_q        <= ref_d;
      pid_q        <= pid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lim_q        <= lim_d;
      hc_q         <= hc_d;
      drain_q      <= drain_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign phase                = phase_q;
  assign reading_particle_num = rpn_q;
  assign pause_reading        = pause_q;
  assign ref_id               = ref_q;
  assign particle_id          = pid_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_pos_read_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pos_read_scheduler
// Each cell run is checked cycle by cycle against a timeline model. The model
// numbers the sweep beats k = 0 .. 2*lim*hc-1 and derives (ref, pid, phase)
// from k with plain arithmetic. Paused cycles and stall counts follow from
// the back_pressure values that the bench itself drove.
// ---------------------------------------------------------------------------
module tb_pos_read_scheduler;

  localparam int W = 7;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bp = 1'b0;
  logic [W-1:0] hcnt = '0;
  logic [W-1:0] nbcnt = '0;
  logic         phase, rpn, pause_reading, busy, done;
  logic [W-1:0] ref_id, particle_id;

  int n_vec = 0;
  int n_bad = 0;

  pos_read_scheduler #(.PARTICLE_ID_WIDTH(W), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .start(start), .home_count(hcnt),
    .nb_max_count(nbcnt), .back_pressure(bp), .phase(phase),
    .reading_particle_num(rpn), .pause_reading(pause_reading),
    .ref_id(ref_id), .particle_id(particle_id), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef logic [18:0] vec_t;

  typedef struct {
    int    hc;
    int    nb;
    int    bp_at;
    int    bp_len;
    int    pct;
    bit    noise;
    bit    hold;
    int    rst_at;
    int    exp_cycles;
    string name;
  } row_t;

  function automatic vec_t pack(bit ph, bit rp, bit pr, logic [W-1:0] r,
                                logic [W-1:0] p, bit b, bit d);
    return {ph, rp, pr, r, p, b, d};
  endfunction

  task automatic check(input string name, input vec_t exp);
    vec_t act;
    act = {phase, rpn, pause_reading, ref_id, particle_id, busy, done};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got ph/rpn/pause/ref/pid/busy/done=%0d/%0d/%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d/%0d/%0d",
               name, $time, act[18], act[17], act[16], act[15:9], act[8:2],
               act[1], act[0], exp[18], exp[17], exp[16], exp[15:9], exp[8:2],
               exp[1], exp[0]);
    end
  endtask

  // mode: 0 count read, 1 latch, 2 sweep, 3 drain, 4 done, 5 idle
  task automatic run_cell(input row_t c);
    int   mode, k, paused, drain_left, burst, lim, total, busy_cnt, model_cycles, want;
    bit   bpv, aborted;
    vec_t e;
    lim = (c.nb > c.hc) ? c.nb : c.hc;
    total = 2 * lim * c.hc;
    mode = 0; k = 0; paused = 0; drain_left = 0; burst = 0;
    busy_cnt = 0; model_cycles = 0; aborted = 0;
    hcnt = W'(c.hc); nbcnt = W'(c.nb); bp = 1'b0; start = 1'b1;
    @(negedge clk);
    if (!c.hold) start = 1'b0;
    while (mode != 5) begin
      case (mode)
        0: e = pack(1'b0, 1'b1, 1'b0, W'(1), W'(0), 1'b1, 1'b0);
        1: e = pack(1'b0, 1'b0, 1'b0, W'(1), W'(0), 1'b1, 1'b0);
        2: e = pack(k[0], 1'b0, paused[0], W'(k / (2 * lim) + 1),
                    W'((k % (2 * lim)) / 2 + 1), 1'b1, 1'b0);
        3: e = pack(1'b0, 1'b0, 1'b0, W'(c.hc + 1), W'((c.hc == 0) ? 0 : 1), 1'b1, 1'b0);
        default: e = pack(1'b0, 1'b0, 1'b0, W'(c.hc + 1), W'((c.hc == 0) ? 0 : 1), 1'b1, 1'b1);
      endcase
      check(c.name, e);
      if (busy) busy_cnt++;
      model_cycles++;
      // Counts are only required through LATCH; scramble them afterwards.
      if (mode >= 2) begin
        hcnt = W'($urandom);
        nbcnt = W'($urandom);
      end
      bpv = ($urandom_range(99) < c.pct);
      if (mode == 2 && k == c.bp_at && burst < c.bp_len) begin
        bpv = 1'b1;
        burst++;
      end
      bp = bpv;
      if (c.noise && !c.hold) start = (mode == 4) || ($urandom_range(99) < 20);
      if (mode == 2 && k == c.rst_at && paused == 0) begin
        #2 rst = 1'b0;
        #1 check({c.name, "_async_rst"}, pack(1'b0, 1'b0, 1'b0, W'(1), W'(0), 1'b0, 1'b0));
        bp = 1'b0; start = 1'b0;
        @(negedge clk);
        check({c.name, "_rst_hold"}, pack(1'b0, 1'b0, 1'b0, W'(1), W'(0), 1'b0, 1'b0));
        rst = 1'b1;
        aborted = 1;
        mode = 5;
      end else begin
        case (mode)
          0: mode = 1;
          1: begin
            if (c.hc == 0) begin mode = 3; drain_left = D; end
            else begin mode = 2; k = 0; paused = 0; end
          end
          2: begin
            if (bpv) paused = 1;
            else begin
              paused = 0;
              k++;
              if (k == total) begin mode = 3; drain_left = D; end
            end
          end
          3: begin
            drain_left--;
            if (drain_left == 0) mode = 4;
          end
          default: mode = 5;
        endcase
      end
      @(negedge clk);
    end
    // Idle afterwards: no retrigger from a held or stray start.
    start = c.hold;
    bp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({c.name, "_idle"}, pack(1'b0, 1'b0, 1'b0, W'(1), W'(0), 1'b0, 1'b0));
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    if (!aborted) begin
      want = (c.exp_cycles >= 0) ? c.exp_cycles : model_cycles;
      n_vec++;
      if (busy_cnt != want) begin
        n_bad++;
        $display("FAIL %s_cycles: got %0d busy cycles want %0d", c.name, busy_cnt, want);
      end
    end
  endtask

  row_t rows[8];
  row_t r;

  initial begin
    rows[0] = '{3,   5, -1, 0,  0, 1'b0, 1'b0, -1, 37,    "hc3_nb5"};
    rows[1] = '{0,   6, -1, 0,  0, 1'b0, 1'b0, -1, 7,     "hc0"};
    rows[2] = '{2,   2,  2, 3,  0, 1'b0, 1'b0, -1, 18,    "bp_burst"};
    rows[3] = '{4,   1, -1, 0,  0, 1'b0, 1'b0, -1, 39,    "lim_from_home"};
    rows[4] = '{2,   3, -1, 0,  0, 1'b1, 1'b0, -1, 19,    "start_noise"};
    rows[5] = '{1,   1, -1, 0,  0, 1'b0, 1'b0, -1, 9,     "hc1_nb1"};
    rows[6] = '{2,   4, -1, 0, 40, 1'b1, 1'b0, -1, -1,    "bp_random"};
    rows[7] = '{127, 3, -1, 0,  0, 1'b0, 1'b0, -1, 32265, "hc_max_wrap"};

    #1 rst = 1'b0;
    #2 check("reset", pack(1'b0, 1'b0, 1'b0, W'(1), W'(0), 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_cell(rows[i]);

    // Reset mid-sweep at ref 2, pid 3 (k = 14 with lim 5), then a fresh full run.
    r = '{3, 5, -1, 0, 0, 1'b0, 1'b0, 14, -1, "rst_mid_sweep"};
    run_cell(r);
    r = '{3, 5, -1, 0, 0, 1'b0, 1'b0, -1, 37, "after_rst"};
    run_cell(r);

    // Start held high for the whole cell and beyond: one cell only.
    r = '{2, 2, -1, 0, 0, 1'b0, 1'b1, -1, 15, "start_held"};
    run_cell(r);

    for (int i = 0; i < 10; i++) begin
      r = '{int'($urandom_range(5)), int'($urandom_range(7)), -1, 0, 25,
            1'b1, 1'b0, -1, -1, "random"};
      run_cell(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
